train_seq: RTL
==============

# train_seq

Parametrised training-pass sequencer for the on-chip learning datapath. Steps the datapath through an initial forward pass, then alternating backward and forward passes, across N_LAYERS layers per pass. It stops on convergence, on an epoch limit, on abort, or on a watchdog timeout. It sits between the top-level control pins and the layer/loss/weight-update units, which it drives with pass-select levels and single-cycle clear pulses.

## Interface
Parameters:
- N_LAYERS, 2: layers traversed per pass (>=1).
- LAYER_W, 1: width of layer_o; must satisfy 2^LAYER_W >= N_LAYERS.
- EPOCH_W, 8: width of epoch limit/counter.
- TIMEOUT_CYC, 255: enabled cycles allowed without a layer-end event; 0 disables watchdog.

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  global enable (top-level ena); 0 freezes all state and suppresses pulses
- init_i  in  1  start/restart a run
- abort_i  in  1  return to IDLE from any state
- max_epochs_i  in  EPOCH_W  backward-pass limit, sampled on start
- f_end_i  in  1  current layer forward step complete
- b_end_i  in  1  current layer backward step complete
- zero_end_check_i  in  1  loss converged to zero
- f0_pass_o, f1_pass_o, b_pass_o  out  1  pass-select levels
- layer_o  out  LAYER_W  active layer index
- epoch_o  out  EPOCH_W  completed backward passes
- zero_loss_o, zero_final_o  out  1  one-cycle clear pulses after each full backward pass
- zero_weight_update_o  out  1  one-cycle pulse after each non-final F1 pass
- busy_o, done_o, error_o  out  1  status levels

## Operation
States: IDLE, F0, B, F1, DONE, ERR. All outputs are registered or decoded from state registers, with no combinational input-to-output path.
- IDLE: all outputs 0.
  - init_i -> F0. On this transition: layer=0, epoch=0, watchdog=0, max_epochs_i latched.
  - If latched limit is 0, go -> DONE instead.
- F0 (f0_pass_o=1): on f_end_i:
  - layer<N_LAYERS-1: layer++.
  - Otherwise -> B, layer=N_LAYERS-1.
- B (b_pass_o=1): layer counts down. On b_end_i:
  - layer>0: layer--.
  - layer==0: -> F1, layer=0, epoch++, zero_loss_o and zero_final_o pulse.
- F1 (f1_pass_o=1): zero_end_check_i -> DONE, with priority over every other F1 event.
  - Else, on f_end_i with layer<N_LAYERS-1: layer++.
  - Else, on f_end_i at last layer and epoch==latched limit: -> DONE.
  - Else, on f_end_i at last layer: -> B, layer=N_LAYERS-1, zero_weight_update_o pulses.
- DONE: done_o=1, layer/epoch hold. init_i restarts exactly as from IDLE.
- ERR: error_o=1, entered on watchdog expiry. Only init_i (restart), abort_i or rst_i leave it.
- busy_o=1 in F0/B/F1.
- abort_i, from any state -> IDLE, with counters cleared. It has priority over init_i and all events.
- Ignored events: f_end_i in B, b_end_i in F0/F1, init_i while busy.
- Watchdog: counts enabled cycles in F0/B/F1. It clears on any accepted f_end_i/b_end_i and on every state change. When the count reaches TIMEOUT_CYC -> ERR.
- Unreachable state encodings -> IDLE next enabled cycle.

## Timing
- Reset: state IDLE; layer_o=0, epoch_o=0; all flag and pulse outputs 0.
- Inputs are sampled only on edges where en_i=1. Holding en_i low holds state, counters and watchdog, and forces pulse outputs to 0.
- Transition latency: an event sampled at edge k gives new state, layer_o and epoch_o valid after edge k. A resulting pulse is high for exactly the cycle after edge k.
- A level input held high is treated as one event per enabled edge. Example: f_end_i held high for N_LAYERS cycles in F0 completes the pass.
- epoch_o cannot wrap: the limit stops the run at most at 2^EPOCH_W-1.
- N_LAYERS=1: layer_o stays 0, and every f_end_i/b_end_i ends its pass.

## Test plan
- **Nominal run** (N_LAYERS=2, max_epochs_i=2): init, then f_end x2, b_end x2, f_end x2, b_end x2, f_end x2.
  - Expect F0->B->F1->B->F1->DONE.
  - zero_loss_o pulses twice, zero_weight_update_o pulses once.
  - Final epoch_o=2, done_o=1.
- **Layer ordering:** layer_o reads 0,1 in F0, 1,0 in B and 0,1 in F1.
- **Convergence:** in the first F1, zero_end_check_i and f_end_i arrive in the same cycle.
  - Expect DONE next cycle, no zero_weight_update_o, epoch_o=1.
- **Limit zero:** max_epochs_i=0 with init -> DONE next cycle, with no pass outputs ever asserted.
- **Enable freeze:** mid-B, hold en_i=0 for 10 cycles while b_end_i pulses.
  - Expect state, layer and watchdog unchanged, no pulses.
  - On resume, the run finishes as nominal.
- **Watchdog/abort** (TIMEOUT_CYC=4):
  - In F0, no events for 4 cycles -> error_o=1, busy_o=0.
  - init_i -> F0 with counters cleared.
  - abort_i in B -> IDLE next cycle.
  - rst_i mid-F1 -> all outputs at reset values.

Source files
------------

// File: rtl/train_seq_if.sv
// Control/status bundle between the top-level pins, the learning datapath and train_seq.
interface train_seq_if #(
  parameter int unsigned LAYER_W = 1,
  parameter int unsigned EPOCH_W = 8
);
  logic               en_i;
  logic               init_i;
  logic               abort_i;
  logic [EPOCH_W-1:0] max_epochs_i;
  logic               f_end_i;
  logic               b_end_i;
  logic               zero_end_check_i;

  logic               f0_pass_o;
  logic               f1_pass_o;
  logic               b_pass_o;
  logic [LAYER_W-1:0] layer_o;
  logic [EPOCH_W-1:0] epoch_o;
  logic               zero_loss_o;
  logic               zero_final_o;
  logic               zero_weight_update_o;
  logic               busy_o;
  logic               done_o;
  logic               error_o;

  // Controller/environment side: drives commands and events, observes status.
  modport master (
    output en_i, init_i, abort_i, max_epochs_i, f_end_i, b_end_i, zero_end_check_i,
    input  f0_pass_o, f1_pass_o, b_pass_o, layer_o, epoch_o, zero_loss_o, zero_final_o,
           zero_weight_update_o, busy_o, done_o, error_o
  );

  // Sequencer side.
  modport slave (
    input  en_i, init_i, abort_i, max_epochs_i, f_end_i, b_end_i, zero_end_check_i,
    output f0_pass_o, f1_pass_o, b_pass_o, layer_o, epoch_o, zero_loss_o, zero_final_o,
           zero_weight_update_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/train_seq.sv
// Training-pass sequencer: F0 pass, then alternating B/F1 passes over N_LAYERS layers,
// ending on convergence, epoch limit, abort or watchdog expiry. All outputs are registered.
module train_seq #(
  parameter int unsigned N_LAYERS    = 2,
  parameter int unsigned LAYER_W     = 1,
  parameter int unsigned EPOCH_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  train_seq_if.slave   bus
);

  localparam int unsigned WD_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_B    = 3'd2,
    S_F1   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t             r_state;
  logic [LAYER_W-1:0] r_layer;
  logic [EPOCH_W-1:0] r_epoch;
  logic [EPOCH_W-1:0] r_limit;
  logic [WD_W-1:0]    r_wdog;
  logic               r_f0_pass;
  logic               r_f1_pass;
  logic               r_b_pass;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_zero_loss;
  logic               r_zero_wu;

  state_t             w_state_nxt;
  logic [LAYER_W-1:0] w_layer_nxt;
  logic [EPOCH_W-1:0] w_epoch_nxt;
  logic [EPOCH_W-1:0] w_limit_nxt;
  logic [WD_W-1:0]    w_wdog_nxt;
  logic               w_zero_loss_nxt;
  logic               w_zero_wu_nxt;
  logic               w_evt;
  logic               w_active;

  assign w_active = (r_state == S_F0) || (r_state == S_B) || (r_state == S_F1);

  // Next-state, counter and pulse decode; abort outranks every other input.
  always_comb begin
    w_state_nxt     = r_state;
    w_layer_nxt     = r_layer;
    w_epoch_nxt     = r_epoch;
    w_limit_nxt     = r_limit;
    w_wdog_nxt      = r_wdog;
    w_zero_loss_nxt = 1'b0;
    w_zero_wu_nxt   = 1'b0;
    w_evt           = 1'b0;

    if (bus.abort_i) begin
      w_state_nxt = S_IDLE;
      w_layer_nxt = '0;
      w_epoch_nxt = '0;
      w_wdog_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.init_i) begin
            w_layer_nxt = '0;
            w_epoch_nxt = '0;
            w_wdog_nxt  = '0;
            w_limit_nxt = bus.max_epochs_i;
            w_state_nxt = (bus.max_epochs_i == '0) ? S_DONE : S_F0;
          end
        end
        S_F0: begin
          if (bus.f_end_i) begin
            w_evt = 1'b1;
            if (r_layer < LAST_LAYER) begin
              w_layer_nxt = r_layer + LAYER_W'(1);
            end else begin
              w_state_nxt = S_B;
              w_layer_nxt = LAST_LAYER;
            end
          end
        end
        S_B: begin
          if (bus.b_end_i) begin
            w_evt = 1'b1;
            if (r_layer != '0) begin
              w_layer_nxt = r_layer - LAYER_W'(1);
            end else begin
              w_state_nxt     = S_F1;
              w_layer_nxt     = '0;
              w_epoch_nxt     = r_epoch + EPOCH_W'(1);
              w_zero_loss_nxt = 1'b1;
            end
          end
        end
        S_F1: begin
          if (bus.zero_end_check_i) begin
            w_evt       = 1'b1;
            w_state_nxt = S_DONE;
          end else if (bus.f_end_i) begin
            w_evt = 1'b1;
            if (r_layer < LAST_LAYER) begin
              w_layer_nxt = r_layer + LAYER_W'(1);
            end else if (r_epoch == r_limit) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt   = S_B;
              w_layer_nxt   = LAST_LAYER;
              w_zero_wu_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_layer_nxt = '0;
          w_epoch_nxt = '0;
          w_wdog_nxt  = '0;
        end
      endcase

      // Watchdog: only quiet cycles inside a pass advance it.
      if (w_active) begin
        if (w_evt || (w_state_nxt != r_state)) begin
          w_wdog_nxt = '0;
        end else if ((TIMEOUT_CYC != 0) && (r_wdog == WD_LAST)) begin
          w_state_nxt = S_ERR;
          w_wdog_nxt  = '0;
        end else if (TIMEOUT_CYC != 0) begin
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end
    end
  end

  // State, counters and registered outputs; en_i low freezes state and kills pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_layer     <= '0;
      r_epoch     <= '0;
      r_limit     <= '0;
      r_wdog      <= '0;
      r_f0_pass   <= 1'b0;
      r_f1_pass   <= 1'b0;
      r_b_pass    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_zero_loss <= 1'b0;
      r_zero_wu   <= 1'b0;
    end else begin
      r_zero_loss <= bus.en_i & w_zero_loss_nxt;
      r_zero_wu   <= bus.en_i & w_zero_wu_nxt;
      if (bus.en_i) begin
        r_state   <= w_state_nxt;
        r_layer   <= w_layer_nxt;
        r_epoch   <= w_epoch_nxt;
        r_limit   <= w_limit_nxt;
        r_wdog    <= w_wdog_nxt;
        r_f0_pass <= (w_state_nxt == S_F0);
        r_f1_pass <= (w_state_nxt == S_F1);
        r_b_pass  <= (w_state_nxt == S_B);
        r_busy    <= (w_state_nxt == S_F0) || (w_state_nxt == S_B) || (w_state_nxt == S_F1);
        r_done    <= (w_state_nxt == S_DONE);
        r_error   <= (w_state_nxt == S_ERR);
      end
    end
  end

  assign bus.f0_pass_o            = r_f0_pass;
  assign bus.f1_pass_o            = r_f1_pass;
  assign bus.b_pass_o             = r_b_pass;
  assign bus.layer_o              = r_layer;
  assign bus.epoch_o              = r_epoch;
  assign bus.zero_loss_o          = r_zero_loss;
  assign bus.zero_final_o         = r_zero_loss;
  assign bus.zero_weight_update_o = r_zero_wu;
  assign bus.busy_o               = r_busy;
  assign bus.done_o               = r_done;
  assign bus.error_o              = r_error;

endmodule
